round_robin_request_encoder: RTL
================================

// Module: round_robin_request_encoder
// PURPOSE
//  Inverse of the pipeline's binary-to-one-hot decoders. Collects single-cycle request pulses
//  from N sources (e.g. exception/stall causes, writeback ports) into a sticky pending mask.
//  Drains the mask one index at a time, round-robin, as a binary index plus its one-hot echo,
//  over a valid/ready handshake. The binary index feeds the CPU control path's cause/select muxes.
// PARAMETERS
//  N  4          number of request sources (>=2)
//  W  $clog2(N)  width of binary index output (derived; do not override)
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-high reset
//  req_set      in   N  request pulses; bit k=1 marks source k pending (OR-in, multi-hot allowed)
//  idx_valid    out  1  output register holds a granted index
//  idx_ready    in   1  consumer accepts idx_out this cycle
//  idx_out      out  W  binary index of granted source
//  onehot_out   out  N  1<<idx_out when idx_valid, else 0
//  pending_out  out  N  current pending mask (registered)
//  any_pending  out  1  |pending_out
// BEHAVIOUR
//  Reset (async, immediate): pending=0, ptr=0, state=EMPTY, idx_valid=0, idx_out=0,
//   onehot_out=0, any_pending=0.
//  Pending update per edge: pending <= (pending & ~take_mask) | req_set. Set wins over take on
//   the same bit: the bit stays pending as a new event.
//  Selection (comb): first set bit of pending, searching from ptr upward, wrapping N-1 -> 0.
//   sel_found=|pending.
//  Output stage FSM, 2 states:
//   EMPTY: if sel_found -> load idx_out=sel, take_mask=1<<sel, ptr<=(sel+1)%N, go FULL.
//          Else stay.
//   FULL:  idx_valid=1. If idx_ready: if sel_found, reload the next index the same edge
//          (back-to-back, 1 per cycle) and stay FULL; else go EMPTY.
//          If !idx_ready: idx_out, onehot_out and ptr are held stable; take_mask=0.
//  Latency: req_set sampled at edge E0 -> pending at E0 -> idx_valid from edge E1.
//   This assumes the stage is EMPTY, or FULL and draining.
//  Throughput: 1 index per cycle while idx_ready=1 and pending is non-zero.
//  A source already held in the output register may be set again; it re-enters pending and is
//   granted later. No event is lost or merged except repeat pulses of an already-pending bit.
//  ptr wraps modulo N. The search never emits an index >= N. For non-power-of-2 N, the
//   unused codes of W are unreachable.
//  idx_valid never drops without a handshake, except by reset.
//  Reset asserted mid-transfer discards the held index and all pending bits.
// STRUCTURE
//  Package cpu_ctrl_pkg:
//   - typedef enum logic {ENC_EMPTY, ENC_FULL} enc_state_t
//   - localparam ENC_N_DEFAULT = 4
//  Sub-module rotating_priority_pick #(N): pure combinational.
//   - inputs: mask[N], ptr[W]
//   - outputs: found, sel[W]
//   - instantiated once here.
//  Top level holds the pending register, ptr register, FSM and output register.
// TESTING (N=4)
//  1. Reset mid-stream while FULL with idx_out=2 -> same cycle: idx_valid=0, onehot_out=0000,
//     pending_out=0000. After release, the first grant searches from ptr=0.
//  2. req_set=0100 one cycle, idx_ready=1 -> idx_valid=1 one edge later with idx_out=2,
//     onehot_out=0100, pending_out=0000. Next cycle idx_valid=0.
//  3. req_set=1111 one cycle, idx_ready=1 -> idx_out 0,1,2,3 on four consecutive cycles,
//     then idx_valid=0, any_pending=0.
//  4. Grant of 1 held with idx_ready=0 for 5 cycles, req_set=0010 in cycle 2 ->
//     idx_out=1 stable all 5 cycles, pending_out=0010. After ready, 1 is emitted again.
//  5. Wrap: after granting 2, pending=1001 -> next grants 3 then 0.
//  6. Simultaneous: req_set bit 1 on the same edge bit 1 is taken -> idx_out=1 and
//     pending_out=0010 afterwards. Bit 1 is granted a second time.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared types and defaults for the CPU control request encoder.
//  Revision    : 1.0
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic {
        ENC_EMPTY = 1'b0,
        ENC_FULL  = 1'b1
    } enc_state_t;

    localparam int ENC_N_DEFAULT = 4;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/round_robin_request_encoder_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rotating_priority_pick
//  Description : Finds the first set mask bit at or above ptr, wrapping N-1 -> 0.
//  Revision    : 1.0
// ============================================================================
module rotating_priority_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] sel
);

    localparam logic [W:0] C_N_WIDE = (W+1)'(N);

    logic [W:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        found  = |mask;
        sel    = '0;
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = {1'b0, ptr} + (W+1)'(k);
            if (w_cand >= C_N_WIDE) begin
                w_cand = w_cand - C_N_WIDE;
            end
            if (mask[w_cand[W-1:0]]) begin
                sel = w_cand[W-1:0];
            end
        end
    end

endmodule : rotating_priority_pick
`default_nettype wire

// File: rtl/round_robin_request_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : round_robin_request_encoder
//  Description : Sticky pending mask of request pulses, drained round-robin as
//                a binary index plus one-hot echo over a valid/ready handshake.
//  Revision    : 1.0
// ============================================================================
module round_robin_request_encoder
    import cpu_ctrl_pkg::*;
#(
    parameter int N = ENC_N_DEFAULT,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_set,
    output logic         idx_valid,
    input  logic         idx_ready,
    output logic [W-1:0] idx_out,
    output logic [N-1:0] onehot_out,
    output logic [N-1:0] pending_out,
    output logic         any_pending
);

    localparam logic [W-1:0] C_LAST_IDX = W'(N - 1);

    enc_state_t   state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] idx_q, idx_d;

    logic         w_sel_found;
    logic [W-1:0] w_sel_idx;
    logic         w_load;
    logic [N-1:0] w_take_mask;

    rotating_priority_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .mask  (pending_q),
        .ptr   (ptr_q),
        .found (w_sel_found),
        .sel   (w_sel_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        w_take_mask = '0;
        // The output register may be (re)filled when empty or when its content leaves this edge.
        w_load      = w_sel_found && ((state_q == ENC_EMPTY) || idx_ready);

        if (w_load) begin
            state_d     = ENC_FULL;
            idx_d       = w_sel_idx;
            w_take_mask = N'(1) << w_sel_idx;
            ptr_d       = (w_sel_idx == C_LAST_IDX) ? '0 : w_sel_idx + W'(1);
        end else if ((state_q == ENC_FULL) && idx_ready) begin
            state_d = ENC_EMPTY;
        end

        // A new pulse on a bit being taken keeps it pending as a fresh event.
        pending_d = (pending_q & ~w_take_mask) | req_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ENC_EMPTY;
            pending_q <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
        end
    end

    assign idx_valid   = (state_q == ENC_FULL);
    assign idx_out     = idx_q;
    assign onehot_out  = idx_valid ? (N'(1) << idx_q) : '0;
    assign pending_out = pending_q;
    assign any_pending = |pending_q;

endmodule : round_robin_request_encoder
`default_nettype wire
